// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, coordinate type and sync bundle
package vga_timing_pkg;
  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: enable-gated shift register of sync bundles, depth 0 is a wire
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter sync_t RST_VAL = '0
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  en,
  input  sync_t d,
  output sync_t q
);
  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_pipe
    sync_t pipe [DEPTH];
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
      end else if (en) begin
        pipe[0] <= d;
        for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign q = pipe[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel strobe, x/y counters, sync/blank decode and delayed sync copies
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV     = 4,
  parameter int   H_DISPLAY   = VGA_H_DISPLAY,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_DISPLAY   = VGA_V_DISPLAY,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   SYNC_DLY    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               p_tick,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic               hsync_dly,
  output logic               vsync_dly,
  output logic               video_on_dly
);
  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
  localparam coord_t HS_BEG = coord_t'(H_DISPLAY + H_FP);
  localparam coord_t HS_END = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam coord_t VS_BEG = coord_t'(V_DISPLAY + V_FP);
  localparam coord_t VS_END = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);
  localparam sync_t DLY_RST = '{hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE, video_on: 1'b0};
  logic [3:0] div;
  coord_t x_nxt, y_nxt;
  logic h_end, v_end;
  sync_t cur, dly;
  // decode from next-state counters so sync/blank registers match x/y in the same cycle
  always_comb begin
    h_end = x == coord_t'(H_TOTAL - 1);
    v_end = y == coord_t'(V_TOTAL - 1);
    x_nxt = p_tick ? (h_end ? '0 : x + 11'd1) : x;
    y_nxt = (p_tick && h_end) ? (v_end ? '0 : y + 11'd1) : y;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div         <= '0;
      p_tick      <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      video_on    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= (div == DIV_MAX) ? '0 : div + 4'd1;
      p_tick      <= div == DIV_MAX;
      x           <= x_nxt;
      y           <= y_nxt;
      hsync       <= (x_nxt >= HS_BEG && x_nxt <= HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= (y_nxt >= VS_BEG && y_nxt <= VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on    <= (x_nxt < coord_t'(H_DISPLAY)) && (y_nxt < coord_t'(V_DISPLAY));
      line_start  <= p_tick && h_end;
      frame_start <= p_tick && h_end && v_end;
    end
  end
  assign cur = '{hsync, vsync, video_on};
  sync_delay_line #(.DEPTH(SYNC_DLY), .RST_VAL(DLY_RST)) u_dly (
    .clk(clk), .reset_n(reset_n), .en(p_tick), .d(cur), .q(dly)
  );
  assign {hsync_dly, vsync_dly, video_on_dly} = dly;
endmodule
